// File: rtl/wb_dest_pkg.sv
// Shared definitions for the write-back destination queue:
// selector encodings, default SP/RA indices and the queue entry layout.
package wb_dest_pkg;

    localparam logic [1:0] SEL_RT = 2'b00;
    localparam logic [1:0] SEL_RD = 2'b01;
    localparam logic [1:0] SEL_SP = 2'b10;
    localparam logic [1:0] SEL_RA = 2'b11;

    localparam int DEF_SP_REG = 29;
    localparam int DEF_RA_REG = 31;

    // Entry address field is sized for the widest register file supported;
    // instances use the low AW bits.
    localparam int ADDR_MAX_W = 8;

    typedef struct packed {
        logic                  valid;
        logic                  is_null;  // destination was r0: keep order, never write
        logic [ADDR_MAX_W-1:0] addr;
    } dest_entry_t;

endpackage

// File: rtl/wb_dest_queue_fifo.sv
// DEPTH-entry circular buffer of destination entries. The whole entry array
// is exposed so the parent can run the pending-write comparators on it.
module dest_fifo
    import wb_dest_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_i,
    input  dest_entry_t             push_entry_i,
    input  logic                    pop_i,
    output dest_entry_t             head_o,
    output logic [CW-1:0]           count_o,
    output dest_entry_t [DEPTH-1:0] entries_o
);

    dest_entry_t [DEPTH-1:0] mem_q;
    logic [PW-1:0]           wr_q, rd_q;
    logic [CW-1:0]           cnt_q, cnt_d;

    // Occupancy next state; push and pop together leave it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage and pointers; popping clears the valid bit so the scoreboard
    // only sees outstanding entries. Pointers wrap naturally (DEPTH is 2**PW).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= push_entry_i;
                wr_q        <= wr_q + PW'(1);
            end
            if (pop_i) begin
                mem_q[rd_q].valid <= 1'b0;
                rd_q              <= rd_q + PW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

    assign head_o    = mem_q[rd_q];
    assign count_o   = cnt_q;
    assign entries_o = mem_q;

endmodule

// File: rtl/wb_dest_queue.sv
// In-order write-back destination queue: decodes the destination at issue,
// pairs the oldest one with arriving write-back data to drive the register
// file write port, and reports pending writes for hazard stalls.
module wb_dest_queue
    import wb_dest_pkg::*;
#(
    parameter  int AW     = 5,
    parameter  int DW     = 32,
    parameter  int DEPTH  = 4,
    parameter  int SP_REG = DEF_SP_REG,
    parameter  int RA_REG = DEF_RA_REG,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          issue_valid,
    output logic          issue_ready,
    input  logic [1:0]    dst_sel,
    input  logic [AW-1:0] rt_field,
    input  logic [AW-1:0] rd_field,
    input  logic          wb_valid,
    input  logic [DW-1:0] wb_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    input  logic [AW-1:0] src_a,
    input  logic [AW-1:0] src_b,
    output logic          busy_a,
    output logic          busy_b,
    output logic [CW-1:0] count,
    output logic          err
);

    localparam logic [AW-1:0] SP_A = AW'(SP_REG);
    localparam logic [AW-1:0] RA_A = AW'(RA_REG);

    logic [AW-1:0]           dec_addr;
    dest_entry_t             new_entry, head;
    dest_entry_t [DEPTH-1:0] entries;
    logic [CW-1:0]           fifo_cnt;
    logic                    push, pop;

    logic          rf_we_q, rf_we_d;
    logic [AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [DW-1:0] rf_wdata_q, rf_wdata_d;
    logic          err_q, err_d;

    // Destination decode from the instruction fields / fixed SP, RA indices.
    always_comb begin
        dec_addr = rt_field;
        case (dst_sel)
            SEL_RT:  dec_addr = rt_field;
            SEL_RD:  dec_addr = rd_field;
            SEL_SP:  dec_addr = SP_A;
            SEL_RA:  dec_addr = RA_A;
            default: dec_addr = rt_field;
        endcase
    end

    assign new_entry.valid   = 1'b1;
    assign new_entry.is_null = (dec_addr == '0);
    assign new_entry.addr    = ADDR_MAX_W'(dec_addr);

    // Full refuses issue regardless of a same-cycle pop; an empty queue
    // cannot pop, so a same-cycle issue is never consumed by that write-back.
    assign issue_ready = (fifo_cnt < CW'(DEPTH));
    assign push        = issue_valid && issue_ready;
    assign pop         = wb_valid && (fifo_cnt != '0);

    dest_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_entry_i (new_entry),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (fifo_cnt),
        .entries_o    (entries)
    );

    // Write-port next state: address/data hold when nothing pops; the error
    // flag latches any write-back that finds the queue empty.
    always_comb begin
        rf_we_d    = pop && !head.is_null;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (pop) begin
            rf_waddr_d = head.addr[AW-1:0];
            rf_wdata_d = wb_data;
        end
        err_d = err_q | (wb_valid && !pop);
    end

    // Registered register-file write port and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            err_q      <= err_d;
        end
    end

    // Pending-write scoreboard: any live non-null entry, plus the write
    // currently being committed, marks a source busy; r0 is never busy.
    always_comb begin
        busy_a = 1'b0;
        busy_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].valid && !entries[i].is_null) begin
                if (entries[i].addr == ADDR_MAX_W'(src_a)) busy_a = 1'b1;
                if (entries[i].addr == ADDR_MAX_W'(src_b)) busy_b = 1'b1;
            end
        end
        if (rf_we_q && rf_waddr_q == src_a) busy_a = 1'b1;
        if (rf_we_q && rf_waddr_q == src_b) busy_b = 1'b1;
        if (src_a == '0) busy_a = 1'b0;
        if (src_b == '0) busy_b = 1'b0;
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign count    = fifo_cnt;
    assign err      = err_q;

endmodule

// File: tb/tb_wb_dest_queue.sv
// Bench for wb_dest_queue: directed scenarios followed by random traffic,
// each cycle compared against a queue-based reference model.
module tb_wb_dest_queue;

    localparam int AW = 5, DW = 32, DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          issue_valid = 1'b0, issue_ready;
    logic [1:0]    dst_sel = '0;
    logic [AW-1:0] rt_field = '0, rd_field = '0;
    logic          wb_valid = 1'b0;
    logic [DW-1:0] wb_data = '0;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] src_a = '0, src_b = '0;
    logic          busy_a, busy_b;
    logic [2:0]    count;
    logic          err;

    wb_dest_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .dst_sel(dst_sel), .rt_field(rt_field), .rd_field(rd_field),
        .wb_valid(wb_valid), .wb_data(wb_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .src_a(src_a), .src_b(src_b), .busy_a(busy_a), .busy_b(busy_b),
        .count(count), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    // Reference model: ordered list of pending destination indices (0 = null).
    int          mq[$];
    bit          m_err, m_we;
    int          m_waddr;
    logic [31:0] m_wdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit mbusy(int s);
        if (s == 0) return 1'b0;
        foreach (mq[i]) if (mq[i] == s) return 1'b1;
        return m_we && (m_waddr == s);
    endfunction

    function automatic int mdec(int sel, int rt, int rd);
        case (sel)
            0:       return rt;
            1:       return rd;
            2:       return 29;
            default: return 31;
        endcase
    endfunction

    task automatic model_clear();
        mq.delete();
        m_err = 0; m_we = 0; m_waddr = 0; m_wdata = '0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 64'(count), 64'(mq.size()));
        chk({tag, ".ready"}, 64'(issue_ready), 64'(mq.size() < DEPTH));
        chk({tag, ".err"}, 64'(err), 64'(m_err));
        chk({tag, ".rf_we"}, 64'(rf_we), 64'(m_we));
        chk({tag, ".rf_waddr"}, 64'(rf_waddr), 64'(m_waddr));
        chk({tag, ".rf_wdata"}, 64'(rf_wdata), 64'(m_wdata));
        chk({tag, ".busy_a"}, 64'(busy_a), 64'(mbusy(int'(src_a))));
        chk({tag, ".busy_b"}, 64'(busy_b), 64'(mbusy(int'(src_b))));
    endtask

    // One clock: drive inputs, advance the model on the edge, check just after.
    task automatic step(input string tag, input bit iv, input int sel, input int rt,
                        input int rd, input bit wv, input logic [31:0] wd,
                        input int sa, input int sb);
        bit push, pop;
        int h;
        issue_valid = iv; dst_sel = 2'(sel); rt_field = AW'(rt); rd_field = AW'(rd);
        wb_valid = wv; wb_data = wd; src_a = AW'(sa); src_b = AW'(sb);
        @(posedge clk);
        push = iv && (mq.size() < DEPTH);
        pop  = wv && (mq.size() > 0);
        m_we = 0;
        if (pop) begin
            h = mq.pop_front();
            m_we = (h != 0);
            m_waddr = h;
            m_wdata = wd;
        end else if (wv) begin
            m_err = 1;
        end
        if (push) mq.push_back(mdec(sel, rt, rd));
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        issue_valid = 0; wb_valid = 0;
        @(posedge clk);
        #1;
        model_clear();
        reset = 1'b0;
    endtask

    initial begin
        model_clear();
        do_reset();
        #1;
        check_all("reset");

        // rd destination, write-back, busy window on r8.
        step("t1.issue", 1, 1, 3, 8, 0, 0, 8, 3);
        step("t1.wb",    0, 0, 0, 0, 1, 32'hDEADBEEF, 8, 0);
        step("t1.after", 0, 0, 0, 0, 0, 0, 8, 0);

        // SP then RA, ordered write-backs.
        step("t2.sp",  1, 2, 0, 0, 0, 0, 29, 31);
        step("t2.ra",  1, 3, 0, 0, 0, 0, 29, 31);
        step("t2.wb1", 0, 0, 0, 0, 1, 32'd1, 29, 31);
        step("t2.wb2", 0, 0, 0, 0, 1, 32'd2, 29, 31);
        step("t2.idle", 0, 0, 0, 0, 0, 0, 29, 31);

        // r0 destination: queued but never written, never busy.
        step("t3.issue", 1, 0, 0, 7, 0, 0, 0, 7);
        step("t3.wb",    0, 0, 0, 0, 1, 32'h55, 0, 7);
        step("t3.idle",  0, 0, 0, 0, 0, 0, 0, 7);

        // Fill to DEPTH, refused 5th issue, issue+wb while full.
        for (int i = 0; i < DEPTH; i++)
            step("t4.fill", 1, 1, 0, 4 + i, 0, 0, 4, 7);
        step("t4.over", 1, 1, 0, 12, 0, 0, 12, 4);
        step("t4.fullwb", 1, 1, 0, 13, 1, 32'hA5A5_0001, 13, 4);
        for (int i = 0; i < 3; i++)
            step("t4.drain", 0, 0, 0, 0, 1, 32'(i), 5, 7);
        step("t4.idle", 0, 0, 0, 0, 0, 0, 7, 6);

        // Empty write-back: sticky error, same-cycle issue survives.
        step("t5.wbempty", 0, 0, 0, 0, 1, 32'h1234, 0, 0);
        step("t5.hold",    0, 0, 0, 0, 0, 0, 0, 0);
        step("t5.issuewb", 1, 1, 0, 9, 1, 32'h77, 9, 0);
        step("t5.wb",      0, 0, 0, 0, 1, 32'h78, 9, 0);

        // Async reset mid-stream with entries queued and wb_valid high.
        for (int i = 0; i < 3; i++)
            step("t6.fill", 1, 0, 10 + i, 0, 0, 0, 10, 11);
        wb_valid = 1; wb_data = 32'hCAFE;
        #2 reset = 1'b1;
        #1;
        chk("t6.async.rf_we", 64'(rf_we), 64'd0);
        chk("t6.async.rf_waddr", 64'(rf_waddr), 64'd0);
        chk("t6.async.rf_wdata", 64'(rf_wdata), 64'd0);
        chk("t6.async.count", 64'(count), 64'd0);
        chk("t6.async.err", 64'(err), 64'd0);
        chk("t6.async.busy_a", 64'(busy_a), 64'd0);
        model_clear();
        do_reset();
        step("t6.post", 0, 0, 0, 0, 0, 0, 10, 11);

        // Random traffic on a small register range to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            int sa, sb;
            if (n % 100 == 99) begin
                do_reset();
                #1;
                check_all("rnd.reset");
            end
            sa = (mq.size() > 0 && $urandom_range(1, 0) == 1) ? mq[$urandom_range(mq.size() - 1, 0)]
                                                              : int'($urandom_range(7, 0));
            sb = (m_we && $urandom_range(1, 0) == 1) ? m_waddr : int'($urandom_range(7, 0));
            step("rnd", bit'($urandom_range(1, 0)), int'($urandom_range(3, 0)),
                 int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
                 bit'($urandom_range(1, 0)), $urandom(), sa, sb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_dest_queue.md
Name: wb_dest_queue

Overview:
- Parametrised successor of the write-register destination mux for the multicycle datapath.
- Selects the write-back destination at issue from rt, rd, SP or RA and queues it in order.
- Each queued destination is paired with the data that arrives at write-back, then drives the register-file write port.
- Exposes a pending-write scoreboard so control can stall on hazards to up to DEPTH outstanding destinations.

Parameters:
AW, 5, register address width (2**AW registers)
DW, 32, write data width
DEPTH, 4, max outstanding destinations; power of two, >=2
SP_REG, 29, register index for selector 2'b10
RA_REG, 31, register index for selector 2'b11

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
issue_valid  in  1  enqueue a destination this cycle
issue_ready  out  1  queue not full
dst_sel  in  2  00 rt, 01 rd, 10 SP_REG, 11 RA_REG
rt_field  in  AW  rt field of instruction
rd_field  in  AW  rd field of instruction
wb_valid  in  1  write-back data for oldest entry present
wb_data  in  DW  write-back data
rf_we  out  1  register-file write enable (registered)
rf_waddr  out  AW  register-file write address (registered)
rf_wdata  out  DW  register-file write data (registered)
src_a  in  AW  source register query A
src_b  in  AW  source register query B
busy_a  out  1  src_a has a pending write
busy_b  out  1  src_b has a pending write
count  out  clog2(DEPTH)+1  entries queued
err  out  1  sticky: write-back with empty queue

Behaviour:
- Reset, asynchronous, any time:
  - Queue empties and pointers clear.
  - rf_we=0, rf_waddr=0, rf_wdata=0, err=0, count=0.
  - An in-flight write-back is discarded.
- Issue:
  - Accepted on a rising edge when issue_valid && issue_ready.
  - issue_ready = (count < DEPTH), independent of wb_valid. A full queue refuses issue even if a write-back pops the same cycle.
  - issue_valid while full is ignored. No state change and no error.
- Destination decode at issue: 00 -> rt_field, 01 -> rd_field, 10 -> SP_REG[AW-1:0], 11 -> RA_REG[AW-1:0].
- Register 0:
  - A decoded address of 0 is still enqueued to preserve ordering, but is marked null.
  - Popping a null entry gives rf_we=0.
- Write-back:
  - wb_valid with count>0 pops the head on the edge.
  - The next cycle shows rf_we=1 (0 if the head was null), rf_waddr=head address and rf_wdata=wb_data.
  - Otherwise rf_we=0 in the following cycle; rf_waddr and rf_wdata hold their last values.
  - Latency: exactly 1 cycle from wb_valid to rf_we.
- wb_valid with count==0: no pop, rf_we=0, err set. err stays set until reset.
- Simultaneous issue and write-back:
  - When 0 < count < DEPTH, both happen and count is unchanged.
  - When count==0, the issue is accepted and the write-back is an error. The same-cycle issue is never popped.
- Scoreboard, combinational:
  - busy_x = (src_x != 0) && (any valid non-null queue entry == src_x, or (rf_we && rf_waddr == src_x)).
  - The rf_we term covers the cycle in which the register file commits.
- Pointers wrap modulo DEPTH. count runs from 0 to DEPTH inclusive.
- Duplicate destinations in the queue are legal. busy stays high until the last matching entry has committed.

Decomposition:
- Package wb_dest_pkg holds:
  - selector encodings SEL_RT, SEL_RD, SEL_SP, SEL_RA;
  - default SP/RA indices;
  - the queue entry struct {valid, null, addr}.
- One sub-module, dest_fifo: a DEPTH-entry circular buffer with push, pop and count. Its entry array is exposed for the scoreboard comparators.
- Decode, output register and scoreboard stay in the top level.

Test Plan:
- Reset, then issue sel=01 with rd_field=5'd8, then wb_valid with wb_data=32'hDEADBEEF. Next cycle: rf_we=1, rf_waddr=8, rf_wdata=32'hDEADBEEF. busy_a (src_a=8) is 1 from the issue through the rf_we cycle, then 0.
- Issue sel=10, then sel=11, then two write-backs with 1 and 2. Writes go to 29 then 31 in order with data 1 then 2.
- Issue sel=00 with rt_field=0, then write-back. rf_we stays 0, count returns to 0, and busy for src 0 is always 0.
- Issue 4 entries (DEPTH=4). issue_ready=0 and count=4; a 5th issue_valid is ignored. Simultaneous issue+wb while full: one pop, no push, count=3.
- wb_valid with an empty queue. err=1 and rf_we=0; err persists until reset asserts.
- Assert reset mid-stream with 3 entries queued and wb_valid high. All outputs go to 0 immediately (asynchronously) and count=0 after release.
